// File: rtl/rrat_pkg.sv
// Shared rename package: architectural/physical register sizing, register
// index typedefs and the hard-wired zero register constant.
package rrat_pkg;

   localparam int unsigned ARCH_REGS      = 32;
   localparam int unsigned PHYS_REG_WIDTH = 6;
   localparam int unsigned ARCH_REG_WIDTH = $clog2(ARCH_REGS);

   typedef logic [ARCH_REG_WIDTH-1:0] arch_reg_t;
   typedef logic [PHYS_REG_WIDTH-1:0] phys_reg_t;

   localparam arch_reg_t ARCH_REG_X0 = '0;

endpackage

// File: rtl/rrat_free_fifo.sv
// Small valid/ready FIFO holding physical register indices on their way back
// to the free list.
//   clk, rst          clock, synchronous active-high reset (discards entries)
//   push, push_data   enqueue; caller must not push while full
//   pop_valid         FIFO not empty
//   pop_ready         consumer takes the head entry
//   pop_data          head entry
//   count, full       registered occupancy and full flag
module rrat_free_fifo
   import rrat_pkg::*;
#(
   parameter type         data_t = phys_reg_t,
   parameter int unsigned DEPTH  = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  data_t                  push_data,
   output logic                   pop_valid,
   input  logic                   pop_ready,
   output data_t                  pop_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full
);

   localparam int unsigned   PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned   CW   = $clog2(DEPTH) + 1;
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   data_t         mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_pop;

   assign pop_valid = (count != '0);
   assign full      = (count == CW'(DEPTH));
   assign do_pop    = pop_valid && pop_ready;
   assign pop_data  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
         end
         if (push && !do_pop) begin
            count <= count + 1'b1;
         end else if (!push && do_pop) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/rrat.sv
// Retirement register alias table. Holds the committed arch->phys map,
// updates it once per retiring instruction, returns the superseded physical
// register through a buffered valid/ready port, and pulses restore_valid
// after a redirecting commit so the speculative RAT can copy rrat_map.
// Optional feature macro: RRAT_DOUBLE_FREE_CHECK_EN (mapped-register bitmap
// and sticky double_free_err; tied to 0 when undefined).
//   clk, rst                   clock, synchronous active-high reset
//   commit_valid/commit_ready  retire handshake
//   commit_rd, commit_pd       destination arch reg and its new phys reg
//   commit_flush               retiring instruction redirects control flow
//   free_valid/free_ready      free-list return handshake, free_pd payload
//   restore_valid              one-cycle pulse: rrat_map is post-flush map
//   rrat_map                   registered committed mapping
//   double_free_err            sticky error flag
module rrat
   import rrat_pkg::*;
#(
   parameter int unsigned ARCH_REGS      = rrat_pkg::ARCH_REGS,
   parameter int unsigned PHYS_REG_WIDTH = rrat_pkg::PHYS_REG_WIDTH,
   parameter int unsigned BUF_DEPTH      = 2
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      commit_valid,
   output logic                                      commit_ready,
   input  logic [$clog2(ARCH_REGS)-1:0]              commit_rd,
   input  logic [PHYS_REG_WIDTH-1:0]                 commit_pd,
   input  logic                                      commit_flush,
   output logic                                      free_valid,
   input  logic                                      free_ready,
   output logic [PHYS_REG_WIDTH-1:0]                 free_pd,
   output logic                                      restore_valid,
   output logic [ARCH_REGS-1:0][PHYS_REG_WIDTH-1:0]  rrat_map,
   output logic                                      double_free_err
);

   localparam int unsigned AW = $clog2(ARCH_REGS);
   localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

   logic                      accept;
   logic                      do_write;
   logic                      fifo_full;
   logic [CW-1:0]             fifo_count;
   logic [PHYS_REG_WIDTH-1:0] old_pd;

   // Ready depends only on registered occupancy, never on free_ready.
   assign commit_ready = (fifo_count < CW'(BUF_DEPTH));
   assign accept       = commit_valid && commit_ready;
   assign do_write     = accept && (commit_rd != AW'(ARCH_REG_X0));
   assign old_pd       = rrat_map[commit_rd];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < ARCH_REGS; i++) begin
            rrat_map[i] <= PHYS_REG_WIDTH'(i);
         end
         restore_valid <= 1'b0;
      end else begin
         if (do_write) begin
            rrat_map[commit_rd] <= commit_pd;
         end
         restore_valid <= accept && commit_flush;
      end
   end

   rrat_free_fifo #(
      .data_t (logic [PHYS_REG_WIDTH-1:0]),
      .DEPTH  (BUF_DEPTH)
   ) u_free_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (do_write && !fifo_full),
      .push_data (old_pd),
      .pop_valid (free_valid),
      .pop_ready (free_ready),
      .pop_data  (free_pd),
      .count     (fifo_count),
      .full      (fifo_full)
   );

`ifdef RRAT_DOUBLE_FREE_CHECK_EN
   localparam int unsigned NUM_PHYS = 2 ** PHYS_REG_WIDTH;

   logic [NUM_PHYS-1:0] mapped;

   // Clear of old precedes set of new so a same-register rewrite stays mapped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_PHYS; i++) begin
            mapped[i] <= (i < ARCH_REGS);
         end
         double_free_err <= 1'b0;
      end else if (do_write) begin
         if (mapped[commit_pd] && (commit_pd != old_pd)) begin
            double_free_err <= 1'b1;
         end
         mapped[old_pd]    <= 1'b0;
         mapped[commit_pd] <= 1'b1;
      end
   end
`else
   assign double_free_err = 1'b0;
`endif

endmodule

// File: tb/tb_rrat.sv
module tb_rrat;

   localparam int DEPTH = 2;

   logic             clk;
   logic             rst;
   logic             commit_valid;
   logic             commit_ready;
   logic [4:0]       commit_rd;
   logic [5:0]       commit_pd;
   logic             commit_flush;
   logic             free_valid;
   logic             free_ready;
   logic [5:0]       free_pd;
   logic             restore_valid;
   logic [31:0][5:0] rrat_map;
   logic             double_free_err;

   int checks = 0;
   int fails  = 0;

   // Reference model
   logic [5:0] mmap [32];
   logic [5:0] free_q [$];
   bit         exp_restore;
   bit [63:0]  mset;
   bit         exp_err;

   rrat #(
      .ARCH_REGS      (32),
      .PHYS_REG_WIDTH (6),
      .BUF_DEPTH      (DEPTH)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .commit_valid    (commit_valid),
      .commit_ready    (commit_ready),
      .commit_rd       (commit_rd),
      .commit_pd       (commit_pd),
      .commit_flush    (commit_flush),
      .free_valid      (free_valid),
      .free_ready      (free_ready),
      .free_pd         (free_pd),
      .restore_valid   (restore_valid),
      .rrat_map        (rrat_map),
      .double_free_err (double_free_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      for (int i = 0; i < 32; i++) mmap[i] = 6'(i);
      free_q.delete();
      exp_restore = 1'b0;
      mset = '0;
      for (int i = 0; i < 32; i++) mset[i] = 1'b1;
      exp_err = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      commit_valid = 1'b0;
      commit_flush = 1'b0;
      commit_rd = '0;
      commit_pd = '0;
      free_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   // Drives one cycle of inputs, advances the model across the edge, and
   // returns at the following negedge where outputs are sampled.
   task automatic drive_cycle(input bit v, input logic [4:0] rd, input logic [5:0] pd,
                              input bit fl, input bit fr);
      bit acc;
      bit pop;
      logic [5:0] old;
      commit_valid = v;
      commit_rd    = rd;
      commit_pd    = pd;
      commit_flush = fl;
      free_ready   = fr;
      acc = v && (free_q.size() < DEPTH);
      pop = (free_q.size() != 0) && fr;
      @(posedge clk);
      if (pop) void'(free_q.pop_front());
      exp_restore = acc && fl;
      if (acc && rd != 5'd0) begin
         old = mmap[rd];
         free_q.push_back(old);
         if (mset[pd] && pd != old) exp_err = 1'b1;
         mset[old] = 1'b0;
         mset[pd]  = 1'b1;
         mmap[rd]  = pd;
      end
      @(negedge clk);
      commit_valid = 1'b0;
      commit_flush = 1'b0;
   endtask

   task automatic test_reset();
      int bad;
      do_reset();
      drive_cycle(0, 0, 0, 0, 1);
      bad = 0;
      for (int i = 0; i < 32; i++) if (rrat_map[i] !== 6'(i)) bad++;
      checks++;
      if (bad != 0) begin
         fails++;
         $display("FAIL reset_map: %0d entries differ, got map[1]=%0d required 1", bad, rrat_map[1]);
      end
      checks++;
      if (free_valid !== 1'b0) begin fails++; $display("FAIL reset_free_valid: got %b required 0", free_valid); end
      checks++;
      if (commit_ready !== 1'b1) begin fails++; $display("FAIL reset_commit_ready: got %b required 1", commit_ready); end
      checks++;
      if (restore_valid !== 1'b0) begin fails++; $display("FAIL reset_restore_valid: got %b required 0", restore_valid); end
      checks++;
      if (double_free_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b required 0", double_free_err); end
   endtask

   task automatic test_single_commit();
      do_reset();
      drive_cycle(1, 5, 40, 0, 1);
      checks++;
      if (free_valid !== 1'b1) begin fails++; $display("FAIL single_free_valid: got %b required 1", free_valid); end
      checks++;
      if (free_pd !== 6'd5) begin fails++; $display("FAIL single_free_pd: got %0d required 5", free_pd); end
      checks++;
      if (rrat_map[5] !== 6'd40) begin fails++; $display("FAIL single_map5: got %0d required 40", rrat_map[5]); end
      drive_cycle(0, 0, 0, 0, 1);
      checks++;
      if (free_valid !== 1'b0) begin fails++; $display("FAIL single_drain: got %b required 0", free_valid); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      drive_cycle(1, 5, 41, 0, 0);
      drive_cycle(1, 5, 42, 0, 0);
      checks++;
      if (free_pd !== 6'd5) begin fails++; $display("FAIL b2b_first: got %0d required 5", free_pd); end
      checks++;
      if (commit_ready !== 1'b0) begin fails++; $display("FAIL b2b_full_ready: got %b required 0", commit_ready); end
      drive_cycle(0, 0, 0, 0, 1);
      checks++;
      if (free_valid !== 1'b1 || free_pd !== 6'd41) begin
         fails++; $display("FAIL b2b_second: got valid=%b pd=%0d required valid=1 pd=41", free_valid, free_pd);
      end
      checks++;
      if (rrat_map[5] !== 6'd42) begin fails++; $display("FAIL b2b_map5: got %0d required 42", rrat_map[5]); end
      drive_cycle(0, 0, 0, 0, 1);
      checks++;
      if (free_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain: got %b required 0", free_valid); end
   endtask

   task automatic test_x0();
      int bad;
      do_reset();
      drive_cycle(1, 0, 33, 0, 1);
      checks++;
      if (free_valid !== 1'b0) begin fails++; $display("FAIL x0_free_valid: got %b required 0", free_valid); end
      bad = 0;
      for (int i = 0; i < 32; i++) if (rrat_map[i] !== mmap[i]) bad++;
      checks++;
      if (bad != 0) begin fails++; $display("FAIL x0_map: %0d entries differ, got map[0]=%0d required 0", bad, rrat_map[0]); end
   endtask

   task automatic test_backpressure();
      do_reset();
      drive_cycle(1, 1, 50, 0, 0);
      checks++;
      if (commit_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_one: got %b required 1", commit_ready); end
      drive_cycle(1, 2, 51, 0, 0);
      checks++;
      if (commit_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_full: got %b required 0", commit_ready); end
      drive_cycle(1, 3, 52, 0, 0);
      checks++;
      if (rrat_map[3] !== 6'd3 || commit_ready !== 1'b0) begin
         fails++; $display("FAIL bp_held: got map3=%0d ready=%b required map3=3 ready=0", rrat_map[3], commit_ready);
      end
      checks++;
      if (free_pd !== 6'd1) begin fails++; $display("FAIL bp_head1: got %0d required 1", free_pd); end
      drive_cycle(1, 3, 52, 0, 1);
      checks++;
      if (free_pd !== 6'd2 || commit_ready !== 1'b1 || rrat_map[3] !== 6'd3) begin
         fails++; $display("FAIL bp_after_pop: got pd=%0d ready=%b map3=%0d required pd=2 ready=1 map3=3",
                           free_pd, commit_ready, rrat_map[3]);
      end
      drive_cycle(1, 3, 52, 0, 1);
      checks++;
      if (rrat_map[3] !== 6'd52 || free_pd !== 6'd3) begin
         fails++; $display("FAIL bp_third: got map3=%0d pd=%0d required map3=52 pd=3", rrat_map[3], free_pd);
      end
      drive_cycle(0, 0, 0, 0, 1);
   endtask

   task automatic test_flush();
      do_reset();
      drive_cycle(1, 3, 60, 1, 1);
      checks++;
      if (restore_valid !== 1'b1 || rrat_map[3] !== 6'd60) begin
         fails++; $display("FAIL flush_pulse: got restore=%b map3=%0d required restore=1 map3=60", restore_valid, rrat_map[3]);
      end
      checks++;
      if (free_valid !== 1'b1 || free_pd !== 6'd3) begin
         fails++; $display("FAIL flush_buffer_kept: got valid=%b pd=%0d required valid=1 pd=3", free_valid, free_pd);
      end
      drive_cycle(0, 0, 0, 0, 1);
      checks++;
      if (restore_valid !== 1'b0) begin fails++; $display("FAIL flush_one_cycle: got %b required 0", restore_valid); end
   endtask

   task automatic test_random();
      int bad;
      bit v;
      bit fl;
      bit fr;
      do_reset();
      for (int n = 0; n < 400; n++) begin
         v  = ($urandom_range(0, 9) < 7);
         fl = ($urandom_range(0, 4) == 0);
         fr = ($urandom_range(0, 1) == 1);
         drive_cycle(v, 5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)), fl, fr);
         checks++;
         if (commit_ready !== (free_q.size() < DEPTH)) begin
            fails++; $display("FAIL rnd_ready cyc%0d: got %b required %b", n, commit_ready, free_q.size() < DEPTH);
         end
         checks++;
         if (free_valid !== (free_q.size() != 0)) begin
            fails++; $display("FAIL rnd_free_valid cyc%0d: got %b required %b", n, free_valid, free_q.size() != 0);
         end
         if (free_q.size() != 0) begin
            checks++;
            if (free_pd !== free_q[0]) begin
               fails++; $display("FAIL rnd_free_pd cyc%0d: got %0d required %0d", n, free_pd, free_q[0]);
            end
         end
         checks++;
         if (restore_valid !== exp_restore) begin
            fails++; $display("FAIL rnd_restore cyc%0d: got %b required %b", n, restore_valid, exp_restore);
         end
         bad = 0;
         for (int i = 0; i < 32; i++) if (rrat_map[i] !== mmap[i]) bad++;
         checks++;
         if (bad != 0) begin fails++; $display("FAIL rnd_map cyc%0d: %0d entries differ", n, bad); end
`ifdef RRAT_DOUBLE_FREE_CHECK_EN
         checks++;
         if (double_free_err !== exp_err) begin
            fails++; $display("FAIL rnd_err cyc%0d: got %b required %b", n, double_free_err, exp_err);
         end
`endif
      end
   endtask

`ifdef RRAT_DOUBLE_FREE_CHECK_EN
   task automatic test_double_free();
      do_reset();
      drive_cycle(1, 4, 7, 0, 1);
      checks++;
      if (double_free_err !== 1'b1) begin fails++; $display("FAIL dfree_set: got %b required 1", double_free_err); end
      drive_cycle(0, 0, 0, 0, 1);
      drive_cycle(1, 9, 45, 0, 1);
      checks++;
      if (double_free_err !== 1'b1) begin fails++; $display("FAIL dfree_sticky: got %b required 1", double_free_err); end
   endtask
`endif

   initial begin
      rst = 1'b1;
      commit_valid = 1'b0;
      commit_flush = 1'b0;
      commit_rd = '0;
      commit_pd = '0;
      free_ready = 1'b1;
      test_reset();
      test_single_commit();
      test_back_to_back();
      test_x0();
      test_backpressure();
      test_flush();
`ifdef RRAT_DOUBLE_FREE_CHECK_EN
      test_double_free();
`endif
      test_random();
      test_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/rrat.md
# rrat

Retirement register alias table for the rename stage. It holds the committed architectural-to-physical mapping and updates it once per committing instruction. It returns the superseded physical register to the free list's enqueue side through a small buffered valid/ready port. When a redirecting branch or jump commits, it supplies the committed map so the speculative RAT can be restored.

## Interface
- ARCH_REGS, 32, number of architectural registers; x0 is never renamed
- PHYS_REG_WIDTH, 6, physical register index width (64 physical registers)
- BUF_DEPTH, 2, depth of the free-return buffer; must be a power of two and at least 1
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- commit_valid  in  1  ROB head is retiring this cycle
- commit_ready  out  1  RRAT can accept a commit this cycle
- commit_rd  in  $clog2(ARCH_REGS)  architectural destination of the retiring instruction
- commit_pd  in  PHYS_REG_WIDTH  physical destination allocated at rename
- commit_flush  in  1  retiring instruction redirects control flow (jump_commit)
- free_valid  out  1  free_pd holds a register to return to the free list
- free_ready  in  1  free list can enqueue (driven as !full)
- free_pd  out  PHYS_REG_WIDTH  physical register being freed
- restore_valid  out  1  one-cycle pulse: rrat_map is the post-flush committed map
- rrat_map  out  ARCH_REGS x PHYS_REG_WIDTH  current committed mapping, registered
- double_free_err  out  1  sticky error flag; present only when the macro is defined

## Operation
- A commit is accepted when commit_valid && commit_ready.
- Accepted commit with commit_rd != 0:
  - read old = map[commit_rd];
  - write map[commit_rd] <= commit_pd;
  - push old into the free buffer.
- Accepted commit with commit_rd == 0: no map write and no push. The renamer never allocates a register for x0.
- Commit throughput is one per cycle. A table write lands at the clock edge, so a back-to-back commit to the same rd reads the just-written value.
- Free buffer is a FIFO of BUF_DEPTH entries:
  - free_valid = !empty;
  - pop on free_valid && free_ready;
  - free_pd is the head entry.
- commit_ready = (count < BUF_DEPTH), computed from registered count only. There is no combinational path from free_ready to commit_ready.
- Push and pop in the same cycle: count is unchanged and FIFO order is preserved.
- Flush handling:
  - an accepted commit with commit_flush applies its own map update first;
  - restore_valid is high for the following single cycle, with rrat_map already containing that update;
  - the free buffer is not cleared, because its entries are genuinely free.
- commit_flush while commit_valid is low or commit_ready is low is ignored.
- Mid-operation reset discards buffered entries and restores the identity map.

## Timing
- Reset values:
  - map[i] = i;
  - free_valid 0;
  - commit_ready 1;
  - restore_valid 0;
  - double_free_err 0;
  - FIFO pointers and count 0.
- Commit accepted at edge N: free_valid and the new free_pd are visible after edge N, and rrat_map is updated after edge N.
- restore_valid asserts after edge N and deasserts after edge N+1.
- Full buffer with free_ready low: commit_ready is 0 and the ROB stalls. One pop raises commit_ready on the next cycle.
- Pointer wrap: the FIFO indices wrap modulo BUF_DEPTH. Count is held in $clog2(BUF_DEPTH)+1 bits.

## Configuration
- RRAT_DOUBLE_FREE_CHECK_EN defined:
  - keep a 2^PHYS_REG_WIDTH-bit mapped bitmap, with bits 0..ARCH_REGS-1 set at reset;
  - on an accepted commit with rd != 0, clear bit old and set bit commit_pd;
  - if commit_pd is already set and is not the same as old, set double_free_err, which stays set until reset.
- Macro undefined: no bitmap is built, and double_free_err is tied to 0.

## Structure
- Shared rename package:
  - ARCH_REGS;
  - PHYS_REG_WIDTH;
  - typedefs arch_reg_t and phys_reg_t;
  - the constant ARCH_REG_X0 = 0.
- Sub-module rrat_free_fifo: a parameterized valid/ready FIFO holding phys_reg_t, exposing count and full.

## Test plan
- Reset, then an idle cycle:
  - rrat_map[i] == i for all i;
  - free_valid 0;
  - commit_ready 1.
- Commit rd=5, pd=40 with free_ready=1:
  - next cycle free_valid=1 and free_pd=5;
  - map[5]=40.
- Commit rd=5, pd=41, then the next cycle commit rd=5, pd=42:
  - free sequence is 5, then 41;
  - map[5]=42.
- Commit rd=0, pd=33:
  - no free_valid;
  - map unchanged.
- free_ready=0, then commits to rd=1 and rd=2 with pd=50 and pd=51:
  - commit_ready drops to 0 after the second commit;
  - a third commit is held;
  - raising free_ready yields free_pd 1, then 2, and the third commit is accepted.
- Flush commit rd=3, pd=60:
  - next cycle restore_valid=1 for exactly one cycle;
  - map[3]=60.
- With the macro defined, commit rd=4, pd=7 while p7 is mapped to x7: double_free_err=1 and stays set until reset.
